// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage. Passes EX results to WB, runs loads and
// stores on a req/ack data-memory port with variable wait states, sizes and
// extends load data, flags misalignment and bus timeout, and stalls upstream
// while an access is in flight.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   ex_*                instruction from EX/MEM (held stable while stalled)
//   dmem_*              data-memory request/ack port (word addressed, byte lanes)
//   mem_wd/wreg/wdata_o writeback payload toward MEM/WB
//   stall_req_o         hold EX/MEM and earlier stages
//   excp_o/excp_code_o  exception strobe, 01 misaligned, 10 bus timeout
module mem_stage_ls #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [3:0]        ex_mem_op_i,
  input  logic [ADDR_W-1:0] ex_mem_addr_i,
  input  logic [31:0]       ex_mem_wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_sel_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic [REG_AW-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [31:0]       mem_wdata_o,
  output logic              stall_req_o,
  output logic              excp_o,
  output logic [1:0]        excp_code_o
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_timeout;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_misalign;
  logic              w_go;
  logic [3:0]        w_sel;
  logic [31:0]       w_store_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;

  // Operation decode; codes 9-15 behave as non-memory ops
  always_comb begin
    w_is_load  = (ex_mem_op_i >= OP_LB) && (ex_mem_op_i <= OP_LW);
    w_is_store = (ex_mem_op_i >= OP_SB) && (ex_mem_op_i <= OP_SW);
    w_is_mem   = w_is_load || w_is_store;
    w_is_half  = (ex_mem_op_i == OP_LH) || (ex_mem_op_i == OP_LHU) || (ex_mem_op_i == OP_SH);
    w_is_word  = (ex_mem_op_i == OP_LW) || (ex_mem_op_i == OP_SW);
    w_misalign = (w_is_half && ex_mem_addr_i[0]) || (w_is_word && (ex_mem_addr_i[1:0] != 2'b00));
    w_go       = ex_valid_i && w_is_mem && !w_misalign;
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    w_sel        = 4'b0000;
    w_store_data = ex_mem_wdata_i;
    case (ex_mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        w_sel        = 4'b0001 << ex_mem_addr_i[1:0];
        w_store_data = {4{ex_mem_wdata_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        w_sel        = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{ex_mem_wdata_i[15:0]}};
      end
      OP_LW, OP_SW: w_sel = 4'b1111;
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured word
  always_comb begin
    case (ex_mem_addr_i[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = ex_mem_addr_i[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (ex_mem_op_i)
      OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_ext = {24'd0, w_byte};
      OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = r_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Wait counter, captured read data and timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (dmem_ack_i) begin
        r_rdata   <= dmem_rdata_i;
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (r_state == S_IDLE) begin
      r_timeout <= 1'b0;
    end
  end

  // Next-state logic; an ack on the last allowed cycle still completes normally
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_BUSY;
      S_BUSY:  if (dmem_ack_i || (r_cnt == CNT_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; reset and an empty slot force every output low
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_sel_o   = 4'b0000;
    dmem_wdata_o = 32'd0;
    mem_wd_o     = '0;
    mem_wreg_o   = 1'b0;
    mem_wdata_o  = 32'd0;
    stall_req_o  = 1'b0;
    excp_o       = 1'b0;
    excp_code_o  = 2'b00;
    if (rst && ex_valid_i) begin
      mem_wd_o = ex_wd_i;
      if (!w_is_mem) begin
        mem_wreg_o  = ex_wreg_i;
        mem_wdata_o = ex_wdata_i;
      end else if (w_misalign) begin
        excp_o      = 1'b1;
        excp_code_o = 2'b01;
      end else begin
        case (r_state)
          S_IDLE: stall_req_o = 1'b1;
          S_BUSY: begin
            stall_req_o  = 1'b1;
            dmem_req_o   = 1'b1;
            dmem_we_o    = w_is_store;
            dmem_addr_o  = {ex_mem_addr_i[ADDR_W-1:2], 2'b00};
            dmem_sel_o   = w_sel;
            dmem_wdata_o = w_is_store ? w_store_data : 32'd0;
          end
          S_DONE: begin
            if (r_timeout) begin
              excp_o      = 1'b1;
              excp_code_o = 2'b10;
            end else if (w_is_load) begin
              mem_wreg_o  = ex_wreg_i;
              mem_wdata_o = w_load_ext;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
